pla_activity_sequencer: RTL and testbench

Stimulus sequencer and activity monitor for the 8-input combinational PLA benchmarks (dc2-class) in the power-aware synthesis flow. It applies a controlled series of input vectors to the benchmark, exhaustively or from an LFSR, and waits a programmable settle time per vector. It samples the benchmark's outputs and accumulates output toggle counts and ones counts, which serve as switching-activity and signal-probability estimates for the power reward. It sits between the training-harness control logic and one benchmark instance.

---
 rtl/pla_activity_sequencer.sv | 170 +++++++++++++++++
 tb/tb_pla_activity_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pla_activity_sequencer.sv
// Stimulus sequencer and activity monitor for 8-input PLA benchmarks: applies exhaustive
// or LFSR vectors, waits a settle time per vector, and accumulates output toggle/ones counts.
module pla_activity_sequencer #(
  parameter int OUT_W  = 7,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [7:0]       seed,
  input  logic [15:0]      num_vec,
  output logic [7:0]       pla_in,
  input  logic [OUT_W-1:0] pla_out,
  output logic             busy,
  output logic             done,
  output logic [15:0]      vec_cnt,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [CNT_W-1:0] ones_cnt
);

  localparam int         PC_W        = $clog2(OUT_W + 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [7:0]       r_pla_in;
  logic [OUT_W-1:0] r_prev;
  logic [15:0]      r_vec_cnt;
  logic [15:0]      r_num_vec;
  logic [CNT_W-1:0] r_toggle_cnt;
  logic [CNT_W-1:0] r_ones_cnt;
  logic             r_mode;
  logic             r_have_sample;
  logic [3:0]       r_settle_cnt;

  logic             w_accept;
  logic             w_capture;
  logic             w_last;
  logic [15:0]      w_vec_inc;
  logic [7:0]       w_first_vec;
  logic [7:0]       w_next_vec;
  logic [PC_W-1:0]  w_pop_ones;
  logic [PC_W-1:0]  w_pop_tog;

  function automatic logic [PC_W-1:0] popcount(input logic [OUT_W-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < OUT_W; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

  // Counters stick at all-ones: the carry out of the widened sum selects the clamp.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                               input logic [PC_W-1:0]  inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, acc} + (CNT_W + 1)'(inc);
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  // An all-zero LFSR state would lock up, so a zero seed is nudged to 0x01.
  assign w_first_vec = (mode && (seed == 8'h00)) ? 8'h01 : seed;
  assign w_next_vec  = r_mode ? {r_pla_in[6:0], r_pla_in[7] ^ r_pla_in[5] ^ r_pla_in[4] ^ r_pla_in[3]}
                              : r_pla_in + 8'd1;
  assign w_vec_inc   = r_vec_cnt + 16'd1;
  assign w_last      = (w_vec_inc == r_num_vec);
  assign w_pop_ones  = popcount(pla_out);
  assign w_pop_tog   = r_have_sample ? popcount(pla_out ^ r_prev) : '0;

  // NOTE: sequential state is written with non-blocking assignments so every register
  // samples pre-edge values and the order of statements cannot change the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = (num_vec == 16'd0) ? S_DONE : S_SETTLE;
        end
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (r_settle_cnt == SETTLE_LAST) begin
          w_next_state = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        busy         = 1'b1;
        w_capture    = 1'b1;
        w_next_state = w_last ? S_DONE : S_SETTLE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pla_in      <= '0;
      r_prev        <= '0;
      r_vec_cnt     <= '0;
      r_num_vec     <= '0;
      r_toggle_cnt  <= '0;
      r_ones_cnt    <= '0;
      r_mode        <= 1'b0;
      r_have_sample <= 1'b0;
      r_settle_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_vec_cnt     <= '0;
        r_toggle_cnt  <= '0;
        r_ones_cnt    <= '0;
        r_have_sample <= 1'b0;
        r_mode        <= mode;
        r_num_vec     <= num_vec;
        if (num_vec != 16'd0) begin
          r_pla_in     <= w_first_vec;
          r_settle_cnt <= '0;
        end
      end
      if (r_state == S_SETTLE) begin
        r_settle_cnt <= r_settle_cnt + 4'd1;
      end
      if (w_capture) begin
        r_prev        <= pla_out;
        r_ones_cnt    <= sat_add(r_ones_cnt, w_pop_ones);
        r_toggle_cnt  <= sat_add(r_toggle_cnt, w_pop_tog);
        r_vec_cnt     <= w_vec_inc;
        r_have_sample <= 1'b1;
        r_settle_cnt  <= '0;
        if (!w_last) begin
          r_pla_in <= w_next_vec;
        end
      end
    end
  end

  assign pla_in     = r_pla_in;
  assign vec_cnt    = r_vec_cnt;
  assign toggle_cnt = r_toggle_cnt;
  assign ones_cnt   = r_ones_cnt;

endmodule

// File: tb/tb_pla_activity_sequencer.sv
// Self-checking bench for pla_activity_sequencer: fixed vector table, hand-written corner
// sequences, and randomized runs against a vector-level reference model.
module tb_pla_activity_sequencer;

  localparam int OUT_W      = 7;
  localparam int SETTLE     = 1;
  localparam int CNT_W      = 24;
  localparam int SAT_SETTLE = 3;
  localparam int SAT_CNT_W  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 start;
  logic                 start_sat;
  logic                 mode;
  logic [7:0]           seed;
  logic [15:0]          num_vec;
  logic [7:0]           pla_in;
  logic [OUT_W-1:0]     pla_out;
  logic                 busy;
  logic                 done;
  logic [15:0]          vec_cnt;
  logic [CNT_W-1:0]     toggle_cnt;
  logic [CNT_W-1:0]     ones_cnt;

  logic [7:0]           pla_in_s;
  logic [OUT_W-1:0]     pla_out_s;
  logic                 busy_s;
  logic                 done_s;
  logic [15:0]          vec_cnt_s;
  logic [SAT_CNT_W-1:0] toggle_cnt_s;
  logic [SAT_CNT_W-1:0] ones_cnt_s;

  int         pla_sel;
  logic [6:0] lut [256];
  int         n_checks;
  int         n_fail;
  logic [7:0] exp_pla_hold;

  // Benchmark stand-ins: 0 = loopback of pla_in[6:0], 1 = constant 0x55, 2 = random truth table.
  function automatic logic [6:0] pla_fn(input int sel, input logic [7:0] v);
    case (sel)
      0:       return v[6:0];
      1:       return 7'h55;
      default: return lut[v];
    endcase
  endfunction

  assign pla_out   = pla_fn(pla_sel, pla_in);
  assign pla_out_s = pla_in_s[6:0];

  pla_activity_sequencer #(.OUT_W(OUT_W), .SETTLE(SETTLE), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed), .num_vec(num_vec),
    .pla_in(pla_in), .pla_out(pla_out), .busy(busy), .done(done), .vec_cnt(vec_cnt),
    .toggle_cnt(toggle_cnt), .ones_cnt(ones_cnt)
  );

  pla_activity_sequencer #(.OUT_W(OUT_W), .SETTLE(SAT_SETTLE), .CNT_W(SAT_CNT_W)) u_sat (
    .clk(clk), .rst(rst), .start(start_sat), .mode(mode), .seed(seed), .num_vec(num_vec),
    .pla_in(pla_in_s), .pla_out(pla_out_s), .busy(busy_s), .done(done_s), .vec_cnt(vec_cnt_s),
    .toggle_cnt(toggle_cnt_s), .ones_cnt(ones_cnt_s)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk the vector list, sum popcounts, clamp to the counter range.
  task automatic model_run(input logic m, input logic [7:0] s, input int n, input int sel,
                           input int cw, input logic [7:0] pla_before,
                           output longint e_tog, output longint e_ones, output logic [7:0] e_pla);
    logic [7:0] v;
    logic [6:0] smp;
    logic [6:0] prev_smp;
    longint     tog;
    longint     ones;
    longint     maxv;
    tog      = 0;
    ones     = 0;
    prev_smp = '0;
    maxv     = (longint'(1) << cw) - 1;
    v        = (m && s == 8'h00) ? 8'h01 : s;
    e_pla    = pla_before;
    for (int k = 0; k < n; k++) begin
      smp   = pla_fn(sel, v);
      ones += $countones(smp);
      if (k > 0) tog += $countones(smp ^ prev_smp);
      prev_smp = smp;
      e_pla    = v;
      v        = m ? {v[6:0], ^(v & 8'hB8)} : v + 8'd1;
    end
    e_tog  = (tog > maxv) ? maxv : tog;
    e_ones = (ones > maxv) ? maxv : ones;
  endtask

  task automatic run_main(input string name, input logic m, input logic [7:0] s,
                          input logic [15:0] n, input int sel, input bit poke,
                          input longint x_tog, input longint x_ones, input logic [7:0] x_pla);
    int cyc;
    int limit;
    int x_done;
    bit busy_seen;
    x_done = (n == 16'd0) ? 1 : int'(n) * (SETTLE + 1) + 1;
    limit  = x_done + 20;
    @(negedge clk);
    mode = m; seed = s; num_vec = n; pla_sel = sel; start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    cyc       = 1;
    busy_seen = 1'b0;
    while (done !== 1'b1 && cyc < limit) begin
      if (busy === 1'b1) busy_seen = 1'b1;
      if (poke && cyc == 3) begin
        start = 1'b1; mode = ~m; seed = s + 8'h11; num_vec = 16'd3;
      end
      if (poke && cyc == 4) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({name, " done cycle"}, (done === 1'b1) ? cyc : -1, x_done);
    check({name, " vec_cnt"}, vec_cnt, n);
    check({name, " toggle_cnt"}, toggle_cnt, x_tog);
    check({name, " ones_cnt"}, ones_cnt, x_ones);
    check({name, " pla_in"}, pla_in, x_pla);
    check({name, " busy at done"}, busy, 0);
    check({name, " busy seen"}, busy_seen, (n != 16'd0));
    @(negedge clk);
    check({name, " done pulse width"}, done, 0);
    check({name, " vec_cnt held"}, vec_cnt, n);
    check({name, " pla_in held"}, pla_in, x_pla);
    exp_pla_hold = x_pla;
  endtask

  task automatic wait_done(input string name, input int limit);
    int c;
    c = 0;
    while (done !== 1'b1 && c < limit) begin
      @(negedge clk);
      c++;
    end
    check({name, " done seen"}, done, 1);
    @(negedge clk);
  endtask

  typedef struct {
    logic       m;
    logic [7:0] s;
    logic [15:0] n;
    int         sel;
    longint     tog;
    longint     ones;
    logic [7:0] pla;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time %0t, expected completion earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    longint     e_tog;
    longint     e_ones;
    logic [7:0] e_pla;
    int         c;
    bit         dseen;
    bit         bseen;

    n_checks = 0;
    n_fail   = 0;
    pla_sel  = 0;
    for (int i = 0; i < 256; i++) lut[i] = 7'($urandom);

    tbl[0] = '{1'b0, 8'h00, 16'd256, 0, 501, 896, 8'hFF};  // exhaustive sweep, loopback
    tbl[1] = '{1'b0, 8'h5A, 16'd0,   0, 0,   0,   8'hFF};  // zero-length, pla_in untouched
    tbl[2] = '{1'b1, 8'h00, 16'd10,  1, 0,   40,  8'h38};  // LFSR, constant 0x55 output
    tbl[3] = '{1'b1, 8'hB8, 16'd2,   0, 2,   6,   8'h70};  // LFSR from 0xB8
    tbl[4] = '{1'b1, 8'h00, 16'd0,   0, 0,   0,   8'h70};  // zero-length after LFSR run

    // Reset held with start asserted.
    rst = 1'b1; start = 1'b1; start_sat = 1'b0; mode = 1'b0; seed = 8'h33; num_vec = 16'd5;
    repeat (3) begin
      @(negedge clk);
      check("reset pla_in", pla_in, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset vec_cnt", vec_cnt, 0);
      check("reset toggle_cnt", toggle_cnt, 0);
      check("reset ones_cnt", ones_cnt, 0);
    end
    rst = 1'b0; start = 1'b0;
    exp_pla_hold = 8'h00;

    for (int i = 0; i < 5; i++) begin
      run_main($sformatf("table[%0d]", i), tbl[i].m, tbl[i].s, tbl[i].n, tbl[i].sel, 1'b0,
               tbl[i].tog, tbl[i].ones, tbl[i].pla);
    end

    // LFSR stepping from a zero seed, one vector per SETTLE+1 cycles.
    @(negedge clk);
    mode = 1'b1; seed = 8'h00; num_vec = 16'd3; pla_sel = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("lfsr vec0", pla_in, 8'h01);
    repeat (2) @(negedge clk);
    check("lfsr vec1", pla_in, 8'h02);
    repeat (2) @(negedge clk);
    check("lfsr vec2", pla_in, 8'h04);
    wait_done("lfsr seq", 20);
    exp_pla_hold = 8'h04;

    // Saturation on the narrow-counter instance.
    @(negedge clk);
    mode = 1'b0; seed = 8'h7F; num_vec = 16'd8; start_sat = 1'b1;
    @(negedge clk);
    start_sat = 1'b0;
    c = 1;
    while (done_s !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("sat done cycle", (done_s === 1'b1) ? c : -1, 8 * (SAT_SETTLE + 1) + 1);
    check("sat vec_cnt", vec_cnt_s, 8);
    check("sat ones_cnt", ones_cnt_s, 15);
    check("sat toggle_cnt", toggle_cnt_s, 15);
    repeat (3) @(negedge clk);
    check("sat ones_cnt held", ones_cnt_s, 15);
    check("sat toggle_cnt held", toggle_cnt_s, 15);

    // Start pulse during a run must be ignored.
    model_run(1'b0, 8'h10, 12, 2, CNT_W, exp_pla_hold, e_tog, e_ones, e_pla);
    run_main("midrun start", 1'b0, 8'h10, 16'd12, 2, 1'b1, e_tog, e_ones, e_pla);

    // Reset while the fifth of twenty vectors is being settled.
    @(negedge clk);
    mode = 1'b1; seed = 8'h9C; num_vec = 16'd20; pla_sel = 2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (vec_cnt !== 16'd4 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("rst-mid reached vector 5", vec_cnt, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst-mid pla_in", pla_in, 0);
    check("rst-mid busy", busy, 0);
    check("rst-mid done", done, 0);
    check("rst-mid vec_cnt", vec_cnt, 0);
    check("rst-mid toggle_cnt", toggle_cnt, 0);
    check("rst-mid ones_cnt", ones_cnt, 0);
    dseen = 1'b0;
    bseen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (done === 1'b1) dseen = 1'b1;
      if (busy === 1'b1) bseen = 1'b1;
    end
    check("rst-mid no done", dseen, 0);
    check("rst-mid stays idle", bseen, 0);
    exp_pla_hold = 8'h00;

    model_run(1'b1, 8'h9C, 20, 2, CNT_W, exp_pla_hold, e_tog, e_ones, e_pla);
    run_main("after reset", 1'b1, 8'h9C, 16'd20, 2, 1'b0, e_tog, e_ones, e_pla);

    // Randomized runs against the reference model.
    for (int r = 0; r < 14; r++) begin
      logic        rm;
      logic [7:0]  rs;
      logic [15:0] rn;
      int          rsel;
      rm   = 1'($urandom_range(0, 1));
      rs   = 8'($urandom);
      rn   = 16'($urandom_range(0, 40));
      rsel = $urandom_range(0, 2);
      model_run(rm, rs, int'(rn), rsel, CNT_W, exp_pla_hold, e_tog, e_ones, e_pla);
      run_main($sformatf("random[%0d] m=%0d s=%0h n=%0d sel=%0d", r, rm, rs, rn, rsel),
               rm, rs, rn, rsel, 1'b0, e_tog, e_ones, e_pla);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
